// File: rtl/fg_pwm_dac.sv
// PWM output stage for the function generator: double-buffers incoming samples
// and applies a new duty value only on a PWM period boundary.
module fg_pwm_dac #(
  parameter int BITWIDTH           = 8,
  parameter int BITWIDTH_PRESCALAR = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [BITWIDTH-1:0]           sample_i,
  input  logic                          sampleValid_STRB_i,
  input  logic                          unsigned_i,
  input  logic [BITWIDTH_PRESCALAR-1:0] prescaler_i,
  input  logic                          overrunClr_i,
  output logic                          pwm_o,
  output logic                          periodStrb_o,
  output logic                          overrun_o,
  output logic [BITWIDTH-1:0]           duty_o
);

  localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

  logic [BITWIDTH_PRESCALAR-1:0] psc_q, psc_d;
  logic [BITWIDTH-1:0]           cnt_q, cnt_d;
  logic [BITWIDTH-1:0]           pending_q, pending_d;
  logic                          pending_valid_q, pending_valid_d;
  logic [BITWIDTH-1:0]           duty_q, duty_d;
  logic                          pwm_q, pwm_d;
  logic                          period_strb_q, period_strb_d;
  logic                          overrun_q, overrun_d;

  logic [BITWIDTH-1:0] conv;
  logic                tick;
  logic                reload;
  logic                overrun_set;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    conv          = unsigned_i ? sample_i
                               : {~sample_i[BITWIDTH-1], sample_i[BITWIDTH-2:0]};
    // ">=" also catches a prescaler lowered below the running count.
    tick          = enable_i && (psc_q >= prescaler_i);
    reload        = tick && (cnt_q == CNT_MAX);
    overrun_set   = sampleValid_STRB_i && pending_valid_q && !reload;

    psc_d           = psc_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    duty_d          = duty_q;
    overrun_d       = overrun_q;

    if (!enable_i) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      psc_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      psc_d = psc_q + 1'b1;
    end

    // Reload consumes the old pending value before a same-cycle capture replaces it.
    if (reload && pending_valid_q) begin
      duty_d          = pending_q;
      pending_valid_d = 1'b0;
    end
    if (sampleValid_STRB_i) begin
      pending_d       = conv;
      pending_valid_d = 1'b1;
    end

    if (overrun_set)       overrun_d = 1'b1;
    else if (overrunClr_i) overrun_d = 1'b0;

    pwm_d         = enable_i && (cnt_q < duty_q);
    period_strb_d = reload;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      psc_q           <= '0;
      cnt_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      duty_q          <= '0;
      pwm_q           <= 1'b0;
      period_strb_q   <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      psc_q           <= psc_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      duty_q          <= duty_d;
      pwm_q           <= pwm_d;
      period_strb_q   <= period_strb_d;
      overrun_q       <= overrun_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign periodStrb_o = period_strb_q;
  assign overrun_o    = overrun_q;
  assign duty_o       = duty_q;

endmodule

// File: tb/tb_fg_pwm_dac.sv
// Self-checking bench for fg_pwm_dac: directed period measurements plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_fg_pwm_dac;

  localparam int PERIOD = 256;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] sample_i;
  logic       sampleValid_STRB_i;
  logic       unsigned_i;
  logic [5:0] prescaler_i;
  logic       overrunClr_i;
  logic       pwm_o;
  logic       periodStrb_o;
  logic       overrun_o;
  logic [7:0] duty_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model: position within the PWM period plus clocks since last tick.
  int m_clks;
  int m_pos;
  int m_duty;
  int m_pending;
  bit m_has_pending;
  bit m_pwm;
  bit m_strb;
  bit m_ovr;

  fg_pwm_dac #(.BITWIDTH(8), .BITWIDTH_PRESCALAR(6)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .sample_i           (sample_i),
    .sampleValid_STRB_i (sampleValid_STRB_i),
    .unsigned_i         (unsigned_i),
    .prescaler_i        (prescaler_i),
    .overrunClr_i       (overrunClr_i),
    .pwm_o              (pwm_o),
    .periodStrb_o       (periodStrb_o),
    .overrun_o          (overrun_o),
    .duty_o             (duty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_clks = 0; m_pos = 0; m_duty = 0; m_pending = 0;
    m_has_pending = 0; m_pwm = 0; m_strb = 0; m_ovr = 0;
  endtask

  // Advance one clock: model computes its next state from the pre-edge inputs,
  // then the bench returns at the following falling edge for sampling.
  task automatic cycle();
    bit ticked, wrapped, consumed;
    int value, n_duty, n_pending;
    bit n_has, n_ovr;
    value     = unsigned_i ? int'(sample_i) : (int'(sample_i) + 128) % 256;
    ticked    = enable_i && (m_clks >= int'(prescaler_i));
    wrapped   = ticked && (m_pos == PERIOD - 1);
    consumed  = wrapped && m_has_pending;
    n_duty    = consumed ? m_pending : m_duty;
    n_has     = sampleValid_STRB_i ? 1'b1 : (consumed ? 1'b0 : m_has_pending);
    n_pending = sampleValid_STRB_i ? value : m_pending;
    n_ovr     = (sampleValid_STRB_i && m_has_pending && !consumed) ? 1'b1
              : (overrunClr_i ? 1'b0 : m_ovr);
    @(posedge clk_i);
    m_pwm  = enable_i && (m_pos < m_duty);
    m_strb = wrapped;
    if (!enable_i) begin
      m_clks = 0; m_pos = 0;
    end else if (ticked) begin
      m_clks = 0; m_pos = (m_pos + 1) % PERIOD;
    end else begin
      m_clks = m_clks + 1;
    end
    m_duty = n_duty; m_pending = n_pending; m_has_pending = n_has; m_ovr = n_ovr;
    @(negedge clk_i);
  endtask

  task automatic strobe(input logic [7:0] s);
    sample_i = s; sampleValid_STRB_i = 1'b1;
    cycle();
    sampleValid_STRB_i = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!periodStrb_o && n < budget);
    checks++;
    if (!periodStrb_o) begin
      errors++;
      $display("FAIL wait_strobe: no periodStrb_o within %0d clocks", budget);
    end
  endtask

  task automatic measure(input int len, output int highs, output int strobes,
                         output int maxrun, output bit last_strb);
    int run;
    highs = 0; strobes = 0; maxrun = 0; run = 0;
    for (int i = 0; i < len; i++) begin
      cycle();
      highs   += int'(pwm_o);
      strobes += int'(periodStrb_o);
      run      = pwm_o ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    last_strb = periodStrb_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 0; sample_i = 0; sampleValid_STRB_i = 0;
    unsigned_i = 1; prescaler_i = 0; overrunClr_i = 0;
    model_reset();
    #3;
    checks += 4;
    if (pwm_o !== 1'b0)        begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_o); end
    if (periodStrb_o !== 1'b0) begin errors++; $display("FAIL reset_strb: got %b want 0", periodStrb_o); end
    if (overrun_o !== 1'b0)    begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
    if (duty_o !== 8'd0)       begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_unsigned();
    int n, highs, strobes, maxrun;
    bit last;
    unsigned_i = 1; prescaler_i = 0; enable_i = 1;
    strobe(8'd64);
    wait_strobe(600, n);
    checks++;
    if (duty_o !== 8'd64) begin errors++; $display("FAIL unsigned_duty: got %0d want 64", duty_o); end
    for (int p = 0; p < 2; p++) begin
      measure(PERIOD, highs, strobes, maxrun, last);
      checks += 3;
      if (highs != 64)  begin errors++; $display("FAIL unsigned_highs: got %0d want 64", highs); end
      if (strobes != 1) begin errors++; $display("FAIL unsigned_strobes: got %0d want 1", strobes); end
      if (!last)        begin errors++; $display("FAIL unsigned_spacing: strobe not at clock 256 (got %b)", last); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] samples [3] = '{8'h80, 8'h00, 8'h7F};
    int         want    [3] = '{0, 128, 255};
    int n, highs, strobes, maxrun;
    bit last;
    unsigned_i = 0;
    for (int k = 0; k < 3; k++) begin
      strobe(samples[k]);
      wait_strobe(600, n);
      checks += 2;
      if (int'(duty_o) != want[k]) begin
        errors++; $display("FAIL signed_duty[%0d]: got %0d want %0d", k, duty_o, want[k]);
      end
      measure(PERIOD, highs, strobes, maxrun, last);
      if (highs != want[k]) begin
        errors++; $display("FAIL signed_highs[%0d]: got %0d want %0d", k, highs, want[k]);
      end
    end
  endtask

  task automatic test_prescaler();
    int n, highs, strobes, maxrun;
    bit last;
    unsigned_i = 1; prescaler_i = 6'd3;
    strobe(8'd128);
    wait_strobe(2200, n);
    wait_strobe(1100, n);
    checks += 5;
    if (n != 1024)         begin errors++; $display("FAIL psc_period: got %0d want 1024", n); end
    if (duty_o !== 8'd128) begin errors++; $display("FAIL psc_duty: got %0d want 128", duty_o); end
    measure(1024, highs, strobes, maxrun, last);
    if (highs != 512)  begin errors++; $display("FAIL psc_highs: got %0d want 512", highs); end
    if (maxrun != 512) begin errors++; $display("FAIL psc_run: got %0d want 512", maxrun); end
    if (strobes != 1 || !last) begin
      errors++; $display("FAIL psc_strobe: got %0d strobes last=%b want 1 at end", strobes, last);
    end
    prescaler_i = 6'd0;
  endtask

  task automatic test_overrun();
    int n;
    unsigned_i = 1;
    wait_strobe(1100, n);
    strobe(8'd10);
    repeat (5) cycle();
    strobe(8'd20);
    checks += 3;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
    wait_strobe(600, n);
    if (duty_o !== 8'd20)   begin errors++; $display("FAIL ovr_duty: got %0d want 20", duty_o); end
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
    overrunClr_i = 1'b1;
    cycle();
    overrunClr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
    // Realign to a period start, then strobe exactly in the reload cycle.
    wait_strobe(600, n);
    strobe(8'd30);
    repeat (254) cycle();
    strobe(8'd40);
    checks += 4;
    if (periodStrb_o !== 1'b1) begin errors++; $display("FAIL reload_strb: got %b want 1", periodStrb_o); end
    if (duty_o !== 8'd30)      begin errors++; $display("FAIL reload_old: got %0d want 30", duty_o); end
    if (overrun_o !== 1'b0)    begin errors++; $display("FAIL reload_no_ovr: got %b want 0", overrun_o); end
    wait_strobe(600, n);
    if (duty_o !== 8'd40)      begin errors++; $display("FAIL reload_new: got %0d want 40", duty_o); end
  endtask

  task automatic test_reset_midrun();
    repeat (2) cycle();
    strobe(8'd50);
    strobe(8'd60);
    checks += 7;
    if (pwm_o !== 1'b1)     begin errors++; $display("FAIL midrst_pre_pwm: got %b want 1", pwm_o); end
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_ovr: got %b want 1", overrun_o); end
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    if (pwm_o !== 1'b0)        begin errors++; $display("FAIL midrst_pwm: got %b want 0", pwm_o); end
    if (periodStrb_o !== 1'b0) begin errors++; $display("FAIL midrst_strb: got %b want 0", periodStrb_o); end
    if (overrun_o !== 1'b0)    begin errors++; $display("FAIL midrst_ovr: got %b want 0", overrun_o); end
    if (duty_o !== 8'd0)       begin errors++; $display("FAIL midrst_duty: got %0d want 0", duty_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    // The discarded pending sample must never reach duty.
    repeat (300) cycle();
    if (duty_o !== 8'd0)       begin errors++; $display("FAIL midrst_discard: got %0d want 0", duty_o); end
  endtask

  task automatic test_enable();
    int n;
    unsigned_i = 1; prescaler_i = 0; enable_i = 1;
    strobe(8'd200);
    wait_strobe(600, n);
    repeat (10) cycle();
    checks += 7;
    if (pwm_o !== 1'b1) begin errors++; $display("FAIL en_pre_pwm: got %b want 1", pwm_o); end
    enable_i = 1'b0;
    cycle();
    if (pwm_o !== 1'b0) begin errors++; $display("FAIL en_off_pwm: got %b want 0", pwm_o); end
    strobe(8'd50);
    repeat (20) cycle();
    if (pwm_o !== 1'b0 || periodStrb_o !== 1'b0) begin
      errors++; $display("FAIL en_off_idle: got pwm=%b strb=%b want 0 0", pwm_o, periodStrb_o);
    end
    if (duty_o !== 8'd200) begin errors++; $display("FAIL en_off_duty: got %0d want 200", duty_o); end
    enable_i = 1'b1;
    wait_strobe(600, n);
    // A frozen-at-zero counter needs a full 256 ticks to reach the first wrap.
    if (n != PERIOD)      begin errors++; $display("FAIL en_first_wrap: got %0d clocks want 256", n); end
    if (duty_o !== 8'd50) begin errors++; $display("FAIL en_duty: got %0d want 50", duty_o); end
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL en_ovr: got %b want 0", overrun_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20000; i++) begin
      sampleValid_STRB_i = ($urandom_range(0, 99) < 2);
      sample_i           = 8'($urandom);
      unsigned_i         = $urandom_range(0, 1);
      overrunClr_i       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) prescaler_i = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) enable_i = ~enable_i;
      cycle();
      checks += 4;
      if (pwm_o !== m_pwm) begin
        errors++; $display("FAIL rand_pwm @%0d: got %b want %b", i, pwm_o, m_pwm);
      end
      if (periodStrb_o !== m_strb) begin
        errors++; $display("FAIL rand_strb @%0d: got %b want %b", i, periodStrb_o, m_strb);
      end
      if (overrun_o !== m_ovr) begin
        errors++; $display("FAIL rand_ovr @%0d: got %b want %b", i, overrun_o, m_ovr);
      end
      if (int'(duty_o) != m_duty) begin
        errors++; $display("FAIL rand_duty @%0d: got %0d want %0d", i, duty_o, m_duty);
      end
    end
    sampleValid_STRB_i = 1'b0;
    overrunClr_i       = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_prescaler();
    test_overrun();
    test_reset_midrun();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
